// File: rtl/symbol_stream_decoder_pkg.sv
// Shared types and size helpers for symbol_stream_decoder.
package symbol_stream_decoder_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   // Largest carry for a symbol plus a carry, after dropping the digit bits.
   function automatic int carry_bits(input int isw, input int lr);
      return isw - lr + 1;
   endfunction

   function automatic int num_steps(input int ns, input int spc);
      return ns / spc;
   endfunction

   function automatic int cnt_bits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/symbol_stream_decoder_group.sv
// symbol_group_resolver: combinational carry chain across one group of symbols.
module symbol_group_resolver
   import symbol_stream_decoder_pkg::*;
#(
   parameter int SPC = 2,
   parameter int ISW = 5,
   parameter int LR  = 4,
   localparam int CB = carry_bits(ISW, LR)
) (
   input  logic [SPC-1:0][ISW-1:0] sym_i,
   input  logic [CB-1:0]           carry_i,
   output logic [SPC-1:0][LR-1:0]  digit_o,
   output logic [CB-1:0]           carry_o
);

   logic [CB-1:0] c;
   logic [ISW:0]  s;

   // Full-width sum keeps every carry bit; the upper bits ripple to the next symbol.
   always_comb begin
      c       = carry_i;
      s       = '0;
      digit_o = '0;
      for (int j = 0; j < SPC; j++) begin
         s          = {1'b0, sym_i[j]} + {{LR{1'b0}}, c};
         digit_o[j] = s[LR-1:0];
         c          = s[ISW:LR];
      end
      carry_o = c;
   end

endmodule

// File: rtl/symbol_stream_decoder.sv
// Redundant-symbol to canonical binary decoder, SYMBOLSPERCYCLE symbols per RUN cycle.
// Optional sticky overflow flag: define SYMBOL_STREAM_DECODER_OVERFLOW_EN.
module symbol_stream_decoder
   import symbol_stream_decoder_pkg::*;
#(
   parameter int NUMSYMBOLS          = 8,
   parameter int INPUTSYMBOLBITWIDTH = 5,
   parameter int LOGRADIX            = 4,
   parameter int SYMBOLSPERCYCLE     = 2,
   localparam int CARRYBITS          = carry_bits(INPUTSYMBOLBITWIDTH, LOGRADIX)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [INPUTSYMBOLBITWIDTH-1:0] data_in [NUMSYMBOLS],
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUMSYMBOLS*LOGRADIX-1:0] data_out,
   output logic [CARRYBITS-1:0]           carry_out,
   output logic                           overflow
);

   localparam int NS       = NUMSYMBOLS;
   localparam int ISW      = INPUTSYMBOLBITWIDTH;
   localparam int LR       = LOGRADIX;
   localparam int SPC      = SYMBOLSPERCYCLE;
   localparam int CB       = CARRYBITS;
   localparam int NUMSTEPS = num_steps(NS, SPC);
   localparam int STEPBITS = cnt_bits(NUMSTEPS);
   localparam int GRP_IN   = SPC * ISW;
   localparam int GRP_OUT  = SPC * LR;
   localparam logic [STEPBITS-1:0] LAST_STEP = STEPBITS'(NUMSTEPS - 1);

   state_e               state_q, state_d;
   logic [STEPBITS-1:0]  step_q, step_d;
   logic [CB-1:0]        carry_q, carry_d;
   logic [CB-1:0]        cout_q, cout_d;
   logic [NS*ISW-1:0]    sym_q, sym_d;
   logic [NS*LR-1:0]     dout_q, dout_d;

   logic [SPC-1:0][ISW-1:0] grp_sym;
   logic [SPC-1:0][LR-1:0]  grp_dig;
   logic [CB-1:0]           grp_carry;

   assign grp_sym = sym_q[step_q*GRP_IN +: GRP_IN];

   symbol_group_resolver #(
      .SPC (SPC),
      .ISW (ISW),
      .LR  (LR)
   ) u_group (
      .sym_i   (grp_sym),
      .carry_i (carry_q),
      .digit_o (grp_dig),
      .carry_o (grp_carry)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      sym_d   = sym_q;
      dout_d  = dout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               for (int i = 0; i < NS; i++) sym_d[i*ISW +: ISW] = data_in[i];
               step_d  = '0;
               carry_d = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            dout_d[step_q*GRP_OUT +: GRP_OUT] = grp_dig;
            carry_d = grp_carry;
            if (step_q == LAST_STEP) begin
               cout_d  = grp_carry;
               state_d = ST_DONE;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         carry_q <= '0;
         cout_q  <= '0;
         sym_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         sym_q   <= sym_d;
         dout_q  <= dout_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign data_out  = dout_q;
   assign carry_out = cout_q;

`ifdef SYMBOL_STREAM_DECODER_OVERFLOW_EN
   logic ovf_q;

   // Sticky: once any word finishes with a nonzero carry, only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (state_q == ST_RUN && step_q == LAST_STEP && grp_carry != '0)
         ovf_q <= 1'b1;
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: doc/symbol_stream_decoder.md
SYMBOL_STREAM_DECODER -- requirements
Module: symbol_stream_decoder

Interface
REQ-001 SHALL have parameter NUMSYMBOLS, default 8, number of redundant symbols per word, power of two.
REQ-002 SHALL have parameter INPUTSYMBOLBITWIDTH, default 5, bits per unsigned input symbol, greater than LOGRADIX.
REQ-003 SHALL have parameter LOGRADIX, default 4, canonical digit width.
REQ-004 SHALL have parameter SYMBOLSPERCYCLE, default 2, symbols resolved per RUN cycle, divides NUMSYMBOLS.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, input word offered.
REQ-008 SHALL have port in_ready, output, 1, decoder can accept a word.
REQ-009 SHALL have port data_in, input, unpacked array of NUMSYMBOLS x INPUTSYMBOLBITWIDTH, unsigned redundant symbols; index 0 least significant.
REQ-010 SHALL have port out_valid, output, 1, result held stable.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port data_out, output, NUMSYMBOLS*LOGRADIX, canonical binary value.
REQ-013 SHALL have port carry_out, output, CARRYBITS = INPUTSYMBOLBITWIDTH-LOGRADIX+1, final carry above data_out MSB.
REQ-014 SHALL have port overflow, output, 1, sticky nonzero-carry flag (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready, capture data_in to symbol register, clear carry and step counter, go RUN.
REQ-017 RUN: each cycle, for group g = step counter, sequentially for each symbol j in group: sum = symbol[g*SPC+j] + carry; digit = sum[LOGRADIX-1:0] to data_out slice; carry = sum >> LOGRADIX.
REQ-018 Carry register SHALL be CARRYBITS wide; sums computed at INPUTSYMBOLBITWIDTH+1 bits; no truncation.
REQ-019 Step counter SHALL count 0..NUMSYMBOLS/SYMBOLSPERCYCLE-1; after last group, go DONE and load carry_out.
REQ-020 Latency: handshake in cycle 0 -> out_valid asserted in cycle NUMSYMBOLS/SYMBOLSPERCYCLE+1.
REQ-021 DONE: data_out, carry_out held stable until out_ready; on out_valid&&out_ready go IDLE next cycle.
REQ-022 No overlap: a new word is never accepted in the cycle a result is consumed; in_valid ignored outside IDLE.
REQ-023 Symbol value all-zero SHALL yield data_out=0, carry_out=0 with identical latency.

Reset
REQ-024 rst SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, data_out=0, carry_out=0, overflow=0, counter and carry 0.
REQ-025 rst during RUN or DONE SHALL abort the word; no result is emitted for it.

Configuration
REQ-026 With SYMBOL_STREAM_DECODER_OVERFLOW_EN defined, overflow SHALL set on entering DONE with nonzero carry and clear only on rst.
REQ-027 Without SYMBOL_STREAM_DECODER_OVERFLOW_EN, overflow SHALL be constant 0 and no flag register exists.

Structure
REQ-028 Shared package SHALL hold FSM state enum typedef and CARRYBITS/NUMSTEPS derivation functions.
REQ-029 One sub-module symbol_group_resolver SHALL implement the combinational per-group carry chain of REQ-017.

Verification (NUMSYMBOLS=8, INPUTSYMBOLBITWIDTH=5, LOGRADIX=4, SYMBOLSPERCYCLE=2)
REQ-030 All symbols 0x1F -> data_out 0x1111110F, carry_out 2, out_valid in cycle 5.
REQ-031 Symbols = digits of 0x89ABCDEF each shifted left 1 -> data_out 0x13579BDE, carry_out 1.
REQ-032 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0, in_valid ignored throughout.
REQ-033 rst asserted in cycle 2 of RUN -> immediate IDLE, no out_valid, next word decodes correctly.
REQ-034 Back-to-back words with out_ready=1 -> one word per 6 cycles, results in order, overflow set only if macro defined.
